// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: next-PC select codes, reset PC and fetch FSM encodings.
package cpu_pkg;

    localparam logic [1:0]  NPC_SEQ = 2'b00;
    localparam logic [1:0]  NPC_BR  = 2'b01;
    localparam logic [1:0]  NPC_J   = 2'b10;
    localparam logic [1:0]  NPC_JR  = 2'b11;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_STALL = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC candidates: sequential, branch, j and jr targets.
module pc_target_calc
    import cpu_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc_d,
    input  logic [15:0] i_imm16,
    input  logic [25:0] i_instr_index,
    input  logic [31:2] i_rs_val,
    output logic [31:0] o_seq,
    output logic [31:0] o_br,
    output logic [31:0] o_j,
    output logic [31:0] o_jr
);

    logic [31:0] w_pcd_plus4;
    logic [31:0] w_br_off;

    assign w_pcd_plus4 = i_pc_d + 32'd4;
    assign w_br_off    = {{14{i_imm16[15]}}, i_imm16, 2'b00};

    assign o_seq = i_pc + 32'd4;
    assign o_br  = w_pcd_plus4 + w_br_off;
    // Region bits come from the delay-slot address, not the jump itself.
    assign o_j   = {w_pcd_plus4[31:28], i_instr_index, 2'b00};
    assign o_jr  = {i_rs_val[31:2], 2'b00};

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC owner: boot/fetch/stall FSM, one-entry redirect slot and next-PC select.
//   ST_BOOT  | one idle cycle after reset, no request
//   ST_FETCH | imem_req high, PC advances on accept
//   ST_STALL | hazard hold, no request, decode ignored
module pc_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              imem_ready,
    input  logic              dec_valid,
    input  logic              is_branch,
    input  logic              br_taken,
    input  logic              is_j,
    input  logic              is_jr,
    input  logic [15:0]       imm16,
    input  logic [25:0]       instr_index,
    input  logic [ADDR_W-1:0] rs_val,
    output logic [ADDR_W-1:0] pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] pc_d,
    output logic [ADDR_W-1:0] pc_link,
    output logic [1:0]        npcsrc,
    output logic              jr_misalign
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pc_d;
    logic              r_pend_vld;
    logic [ADDR_W-1:0] r_pend_tgt;
    logic [1:0]        r_pend_src;
    logic              r_jr_mis;

    logic              w_imem_req;
    logic              w_accept;
    logic              w_capture;
    logic [1:0]        w_cap_src;
    logic [ADDR_W-1:0] w_cap_tgt;
    logic [1:0]        w_npc_src;
    logic [ADDR_W-1:0] w_npc;
    logic [ADDR_W-1:0] w_seq;
    logic [ADDR_W-1:0] w_br;
    logic [ADDR_W-1:0] w_j;
    logic [ADDR_W-1:0] w_jr;

    pc_target_calc u_target (
        .i_pc          (r_pc),
        .i_pc_d        (r_pc_d),
        .i_imm16       (imm16),
        .i_instr_index (instr_index),
        .i_rs_val      (rs_val[31:2]),
        .o_seq         (w_seq),
        .o_br          (w_br),
        .o_j           (w_j),
        .o_jr          (w_jr)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_imem_req  = 1'b0;
        unique case (r_state)
            ST_BOOT:  w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                w_imem_req = 1'b1;
                if (stall) w_state_nxt = ST_STALL;
            end
            ST_STALL: if (!stall) w_state_nxt = ST_FETCH;
            default:  w_state_nxt = ST_BOOT;
        endcase
    end

    assign w_accept  = w_imem_req & imem_ready;
    assign w_capture = dec_valid & ~stall & (is_jr | is_j | (is_branch & br_taken));

    always_comb begin
        w_cap_src = NPC_BR;
        w_cap_tgt = w_br;
        if (is_jr) begin
            w_cap_src = NPC_JR;
            w_cap_tgt = w_jr;
        end else if (is_j) begin
            w_cap_src = NPC_J;
            w_cap_tgt = w_j;
        end
    end

    // A fresh capture is newer than anything pending, so it wins.
    always_comb begin
        w_npc_src = NPC_SEQ;
        w_npc     = w_seq;
        if (w_capture) begin
            w_npc_src = w_cap_src;
            w_npc     = w_cap_tgt;
        end else if (r_pend_vld) begin
            w_npc_src = r_pend_src;
            w_npc     = r_pend_tgt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_pc_d     <= '0;
            r_pend_vld <= 1'b0;
            r_pend_tgt <= '0;
            r_pend_src <= NPC_SEQ;
            r_jr_mis   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_jr_mis <= w_capture & is_jr & (|rs_val[1:0]);
            if (w_accept) begin
                r_pc       <= w_npc;
                r_pc_d     <= r_pc;
                r_pend_vld <= 1'b0;
            end else if (w_capture) begin
                r_pend_vld <= 1'b1;
                r_pend_tgt <= w_cap_tgt;
                r_pend_src <= w_cap_src;
            end
        end
    end

    assign pc          = r_pc;
    assign pc_d        = r_pc_d;
    assign pc_link     = r_pc_d + ADDR_W'(8);
    assign imem_req    = w_imem_req;
    assign npcsrc      = w_accept ? w_npc_src : NPC_SEQ;
    assign jr_misalign = r_jr_mis;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: reset, redirects, handshake stalls, wrap and reset with pending.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        imem_ready = 1'b1;
    logic        dec_valid = 1'b0;
    logic        is_branch = 1'b0;
    logic        br_taken = 1'b0;
    logic        is_j = 1'b0;
    logic        is_jr = 1'b0;
    logic [15:0] imm16 = '0;
    logic [25:0] instr_index = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] pc_d;
    logic [31:0] pc_link;
    logic [1:0]  npcsrc;
    logic        jr_misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .imem_ready  (imem_ready),
        .dec_valid   (dec_valid),
        .is_branch   (is_branch),
        .br_taken    (br_taken),
        .is_j        (is_j),
        .is_jr       (is_jr),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_val      (rs_val),
        .pc          (pc),
        .imem_req    (imem_req),
        .pc_d        (pc_d),
        .pc_link     (pc_link),
        .npcsrc      (npcsrc),
        .jr_misalign (jr_misalign)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_dec();
        dec_valid = 1'b0; is_branch = 1'b0; br_taken = 1'b0; is_j = 1'b0; is_jr = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h3000); end
        checks++; if (pc_d !== 32'h0) begin errors++; $display("FAIL reset_pc_d: got %h expected %h", pc_d, 32'h0); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (npcsrc !== 2'b00) begin errors++; $display("FAIL reset_npcsrc: got %b expected 00", npcsrc); end
        checks++; if (jr_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", jr_misalign); end
        cyc();
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req: got %b expected 0", imem_req); end
        cyc();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fetch_req: got %b expected 1", imem_req); end
        checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL seq_pc0: got %h expected %h", pc, 32'h3000); end
        checks++; if (npcsrc !== 2'b00) begin errors++; $display("FAIL seq_npcsrc: got %b expected 00", npcsrc); end
        cyc();
        checks++; if (pc !== 32'h3004) begin errors++; $display("FAIL seq_pc1: got %h expected %h", pc, 32'h3004); end
        checks++; if (pc_d !== 32'h3000) begin errors++; $display("FAIL seq_pc_d1: got %h expected %h", pc_d, 32'h3000); end
        cyc();
        checks++; if (pc !== 32'h3008) begin errors++; $display("FAIL seq_pc2: got %h expected %h", pc, 32'h3008); end
        checks++; if (pc_link !== 32'h300C) begin errors++; $display("FAIL seq_link: got %h expected %h", pc_link, 32'h300C); end
        cyc();
    endtask

    // pc=300C, pc_d=3008: taken beq back by two words -> 300C - 8 = 3004
    task automatic test_branch();
        dec_valid = 1'b1; is_branch = 1'b1; br_taken = 1'b1; imm16 = 16'hFFFE;
        #1;
        checks++; if (npcsrc !== 2'b01) begin errors++; $display("FAIL br_npcsrc: got %b expected 01", npcsrc); end
        cyc();
        clear_dec();
        #1;
        checks++; if (pc !== 32'h3004) begin errors++; $display("FAIL br_pc: got %h expected %h", pc, 32'h3004); end
        checks++; if (pc_d !== 32'h300C) begin errors++; $display("FAIL br_delay_slot: got %h expected %h", pc_d, 32'h300C); end
        checks++; if (npcsrc !== 2'b00) begin errors++; $display("FAIL br_after_npcsrc: got %b expected 00", npcsrc); end
    endtask

    // j with branch also flagged (j must win); capture with imem_ready=0 goes to pending.
    task automatic test_jump();
        imem_ready = 1'b0;
        dec_valid = 1'b1; is_j = 1'b1; is_branch = 1'b1; br_taken = 1'b1; imm16 = 16'h0001;
        instr_index = 26'h0000C10;
        #1;
        checks++; if (npcsrc !== 2'b00) begin errors++; $display("FAIL j_noacc_npcsrc: got %b expected 00", npcsrc); end
        cyc();
        clear_dec();
        for (int i = 0; i < 2; i++) begin
            checks++; if (pc !== 32'h3004) begin errors++; $display("FAIL j_hold_pc: got %h expected %h", pc, 32'h3004); end
            cyc();
        end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL j_hold_req: got %b expected 1", imem_req); end
        imem_ready = 1'b1;
        #1;
        checks++; if (npcsrc !== 2'b10) begin errors++; $display("FAIL j_npcsrc: got %b expected 10", npcsrc); end
        cyc();
        checks++; if (pc !== 32'h3040) begin errors++; $display("FAIL j_pc: got %h expected %h", pc, 32'h3040); end
        checks++; if (pc_d !== 32'h3004) begin errors++; $display("FAIL j_pc_d: got %h expected %h", pc_d, 32'h3004); end
    endtask

    // jr with every flag high: jr wins, low bits dropped, misalign pulses once.
    task automatic test_jr();
        dec_valid = 1'b1; is_jr = 1'b1; is_j = 1'b1; is_branch = 1'b1; br_taken = 1'b1;
        rs_val = 32'h0000_3105;
        #1;
        checks++; if (npcsrc !== 2'b11) begin errors++; $display("FAIL jr_npcsrc: got %b expected 11", npcsrc); end
        checks++; if (jr_misalign !== 1'b0) begin errors++; $display("FAIL jr_mis_early: got %b expected 0", jr_misalign); end
        cyc();
        clear_dec();
        checks++; if (pc !== 32'h3104) begin errors++; $display("FAIL jr_pc: got %h expected %h", pc, 32'h3104); end
        checks++; if (jr_misalign !== 1'b1) begin errors++; $display("FAIL jr_mis_pulse: got %b expected 1", jr_misalign); end
        cyc();
        checks++; if (jr_misalign !== 1'b0) begin errors++; $display("FAIL jr_mis_end: got %b expected 0", jr_misalign); end
        checks++; if (pc !== 32'h3108) begin errors++; $display("FAIL jr_seq: got %h expected %h", pc, 32'h3108); end
    endtask

    // pc=3108, pc_d=3104. Stall 4 cycles; first stall cycle still accepts (seq to 310C).
    task automatic test_stall();
        stall = 1'b1;
        dec_valid = 1'b1; is_branch = 1'b1; br_taken = 1'b1; imm16 = 16'h0010;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL st_rise_req: got %b expected 1", imem_req); end
        checks++; if (npcsrc !== 2'b00) begin errors++; $display("FAIL st_rise_npcsrc: got %b expected 00", npcsrc); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL st_req: got %b expected 0", imem_req); end
            checks++; if (pc !== 32'h310C) begin errors++; $display("FAIL st_pc: got %h expected %h", pc, 32'h310C); end
        end
        cyc();
        stall = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL st_rel_req: got %b expected 0", imem_req); end
        cyc();
        clear_dec();
        #1;
        checks++; if (npcsrc !== 2'b01) begin errors++; $display("FAIL st_pend_npcsrc: got %b expected 01", npcsrc); end
        cyc();
        // target = 3108 + 4 + (0x10<<2)
        checks++; if (pc !== 32'h314C) begin errors++; $display("FAIL st_pend_pc: got %h expected %h", pc, 32'h314C); end
        checks++; if (pc_d !== 32'h310C) begin errors++; $display("FAIL st_pend_pc_d: got %h expected %h", pc_d, 32'h310C); end
    endtask

    task automatic test_wrap();
        dec_valid = 1'b1; is_jr = 1'b1; rs_val = 32'hFFFF_FFFC;
        cyc();
        clear_dec();
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_jr_pc: got %h expected %h", pc, 32'hFFFF_FFFC); end
        checks++; if (jr_misalign !== 1'b0) begin errors++; $display("FAIL wrap_mis: got %b expected 0", jr_misalign); end
        cyc();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h expected %h", pc, 32'h0); end
        checks++; if (pc_link !== 32'h4) begin errors++; $display("FAIL wrap_link: got %h expected %h", pc_link, 32'h4); end
    endtask

    task automatic test_reset_pending();
        imem_ready = 1'b0;
        dec_valid = 1'b1; is_j = 1'b1; instr_index = 26'h3FF_FFFF;
        cyc();
        clear_dec();
        reset = 1'b1;
        #1;
        checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL rst_mid_pc: got %h expected %h", pc, 32'h3000); end
        checks++; if (pc_d !== 32'h0) begin errors++; $display("FAIL rst_mid_pc_d: got %h expected %h", pc_d, 32'h0); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got %b expected 0", imem_req); end
        cyc();
        reset = 1'b0;
        imem_ready = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_boot_req: got %b expected 0", imem_req); end
        cyc();
        checks++; if (npcsrc !== 2'b00) begin errors++; $display("FAIL rst_pend_cleared: got %b expected 00", npcsrc); end
        cyc();
        checks++; if (pc !== 32'h3004) begin errors++; $display("FAIL rst_seq_pc: got %h expected %h", pc, 32'h3004); end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jump();
        test_jr();
        test_stall();
        test_wrap();
        test_reset_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
